// File: rtl/strng_pkg.sv
// Shared definitions for the strng_ctrl sequencing controller.
package strng_pkg;

  // Controller state encoding, also driven out on the state port.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  // Divider settings for common sample rates from a 50 MHz system clock.
  localparam int DIV_50MHZ = 0;
  localparam int DIV_25MHZ = 1;
  localparam int DIV_10MHZ = 4;
  localparam int DIV_5MHZ  = 9;
  localparam int DIV_2MHZ  = 24;
  localparam int DIV_1MHZ  = 49;

  // True in the states where the divider runs and samples are taken.
  function automatic logic is_active(input state_t st);
    return (st == ST_WARMUP) || (st == ST_RUN);
  endfunction

endpackage

// File: rtl/strng_fifo.sv
// Synchronous first-word fall-through FIFO with flush and occupancy output.
module strng_fifo #(
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          flush,
  input  logic [DW-1:0]                 din,
  output logic [DW-1:0]                 dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_INC = (AW+1)'(1);

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic          do_push;
  logic          do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign level   = wr_ptr_r - rd_ptr_r;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  // Head is forced to zero when empty so stale entries never show.
  assign dout    = empty ? '0 : mem[rd_ptr_r[AW-1:0]];

  // Pointer update; flush discards everything in one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push) wr_ptr_r <= wr_ptr_r + PTR_INC;
      if (do_pop)  rd_ptr_r <= rd_ptr_r + PTR_INC;
    end
  end

  // Storage write; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_r[AW-1:0]] <= din;
  end

endmodule

// File: rtl/strng_ctrl.sv
// Sequencing controller for strng_core: sample strobe divider, warm-up
// discard, repetition-count health test and buffered output stream.
module strng_ctrl import strng_pkg::*; #(
  parameter int DIV_VAL    = DIV_2MHZ,
  parameter int WARMUP     = 256,
  parameter int REP_LIMIT  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DW         = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          en,
  input  logic                          clr_fault,
  input  logic [DW-1:0]                 rnd_data,
  output logic                          sample_en,
  output logic                          rnd_valid,
  input  logic                          rnd_ready,
  output logic [DW-1:0]                 rnd_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [1:0]                    state,
  output logic                          fault
);

  localparam int DIVW = (DIV_VAL > 0) ? $clog2(DIV_VAL + 1) : 1;
  localparam int WW   = $clog2(WARMUP + 1);
  localparam logic [DIVW-1:0] DIV_MAX   = DIVW'(DIV_VAL);
  localparam logic [WW-1:0]   WARM_LAST = WW'(WARMUP - 1);
  localparam logic [7:0]      REP_MAX   = 8'(REP_LIMIT);

  state_t          state_r;
  state_t          state_nxt;
  logic            fault_r;
  logic [DIVW-1:0] div_cnt_r;
  logic [WW-1:0]   warm_cnt_r;
  logic [7:0]      rep_r;
  logic [7:0]      rep_nxt;
  logic [DW-1:0]   last_r;
  logic            first_r;
  logic            hold;
  logic            strobe;
  logic            fail;
  logic            push;
  logic            pop;
  logic            flush;
  logic            full;
  logic            empty;

  // Strobe decode and health test on the byte captured this cycle.
  always_comb begin
    hold    = (state_r == ST_RUN) && full;
    strobe  = is_active(state_r) && !hold && (div_cnt_r == DIV_MAX);
    if (!first_r && (rnd_data == last_r)) begin
      rep_nxt = rep_r + 8'd1;
    end else begin
      rep_nxt = 8'd1;
    end
    fail    = strobe && (rep_nxt == REP_MAX);
    push    = strobe && (state_r == ST_RUN) && !fail;
    flush   = (state_r == ST_FAULT);
    pop     = rnd_valid && rnd_ready;
  end

  // Next state: health failure beats en=0, which beats normal progress.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (en) state_nxt = ST_WARMUP;
        else    state_nxt = ST_IDLE;
      end
      ST_WARMUP: begin
        if (fail)                                   state_nxt = ST_FAULT;
        else if (!en)                               state_nxt = ST_IDLE;
        else if (strobe && (warm_cnt_r == WARM_LAST)) state_nxt = ST_RUN;
        else                                        state_nxt = ST_WARMUP;
      end
      ST_RUN: begin
        if (fail)     state_nxt = ST_FAULT;
        else if (!en) state_nxt = ST_IDLE;
        else          state_nxt = ST_RUN;
      end
      ST_FAULT: begin
        if (clr_fault) state_nxt = ST_IDLE;
        else           state_nxt = ST_FAULT;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register with the fault flag registered alongside it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      fault_r <= 1'b0;
    end else begin
      state_r <= state_nxt;
      fault_r <= (state_nxt == ST_FAULT);
    end
  end

  // Strobe divider; parked at zero outside WARMUP/RUN, frozen under backpressure.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt_r <= '0;
    end else if (!is_active(state_r)) begin
      div_cnt_r <= '0;
    end else if (hold) begin
      div_cnt_r <= div_cnt_r;
    end else if (div_cnt_r == DIV_MAX) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + DIVW'(1);
    end
  end

  // Warm-up sample counter; any exit from WARMUP restarts it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      warm_cnt_r <= '0;
    end else if (state_r != ST_WARMUP) begin
      warm_cnt_r <= '0;
    end else if (strobe) begin
      warm_cnt_r <= warm_cnt_r + WW'(1);
    end
  end

  // Health-test history; IDLE is the only way into WARMUP, so clear it there.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      first_r <= 1'b1;
      rep_r   <= 8'd0;
      last_r  <= '0;
    end else if (state_r == ST_IDLE) begin
      first_r <= 1'b1;
      rep_r   <= 8'd0;
      last_r  <= '0;
    end else if (strobe) begin
      first_r <= 1'b0;
      rep_r   <= rep_nxt;
      last_r  <= rnd_data;
    end
  end

  strng_fifo #(
    .DW         (DW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (rnd_data),
    .dout  (rnd_out),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign sample_en = strobe;
  assign rnd_valid = !empty;
  assign state     = state_r;
  assign fault     = fault_r;

endmodule

// File: tb/tb_strng_ctrl.sv
// Directed bench for strng_ctrl with DIV_VAL=1, WARMUP=4, REP_LIMIT=3, FIFO_DEPTH=4.
module tb_strng_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en;
  logic       clr_fault;
  logic [7:0] rnd_data;
  logic       sample_en;
  logic       rnd_valid;
  logic       rnd_ready;
  logic [7:0] rnd_out;
  logic [2:0] fifo_level;
  logic [1:0] state;
  logic       fault;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] pat [32];
  int         pi;
  logic       last_se;
  logic [7:0] popped [$];
  logic [7:0] exp_pop [9];
  int         waited;

  strng_ctrl #(
    .DIV_VAL    (1),
    .WARMUP     (4),
    .REP_LIMIT  (3),
    .FIFO_DEPTH (4),
    .DW         (8)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .clr_fault  (clr_fault),
    .rnd_data   (rnd_data),
    .sample_en  (sample_en),
    .rnd_valid  (rnd_valid),
    .rnd_ready  (rnd_ready),
    .rnd_out    (rnd_out),
    .fifo_level (fifo_level),
    .state      (state),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  // Mid-cycle monitor: remembers strobes and logs every accepted output byte.
  always @(negedge clk) begin
    last_se <= sample_en;
    if (rnd_valid === 1'b1 && rnd_ready === 1'b1) popped.push_back(rnd_out);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to 2ns after the next rising edge; present the next pattern byte after a strobe.
  task automatic cyc();
    @(posedge clk);
    #2;
    if (last_se === 1'b1) begin
      if (pi < 31) pi++;
      rnd_data = pat[pi];
    end
  endtask

  initial begin
    for (int i = 0; i < 9; i++) pat[i] = 8'h10 + 8'(i);
    for (int i = 0; i < 4; i++) pat[9 + i] = 8'h20 + 8'(i);
    pat[13] = 8'hA5; pat[14] = 8'hA5; pat[15] = 8'hA5;
    for (int i = 0; i < 4; i++) pat[16 + i] = 8'h30 + 8'(i);
    pat[20] = 8'hA5; pat[21] = 8'hA5; pat[22] = 8'h3C; pat[23] = 8'h3C; pat[24] = 8'h3C;
    for (int i = 0; i < 7; i++) pat[25 + i] = 8'h40 + 8'(i);
    exp_pop = '{8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'hA5, 8'hA5, 8'h3C, 8'h3C};

    pi = 0; rnd_data = pat[0];
    rstn = 1'b0; en = 1'b0; clr_fault = 1'b0; rnd_ready = 1'b0;
    cyc(); cyc();
    check_val("rst_state", state, 0);
    check_val("rst_strobe", sample_en, 0);
    check_val("rst_valid", rnd_valid, 0);
    check_val("rst_out", rnd_out, 0);
    check_val("rst_level", fifo_level, 0);
    check_val("rst_fault", fault, 0);
    rstn = 1'b1;
    cyc();
    check_val("idle_state", state, 0);
    check_val("idle_strobe", sample_en, 0);

    // Warm-up then RUN, incrementing data; strobe every second cycle.
    en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      check_val("t1_strobe", sample_en, (k % 2 == 0) ? 1 : 0);
      check_val("t1_state", state, (k <= 8) ? 1 : 2);
      check_val("t1_valid", rnd_valid, 0);
    end
    cyc();
    check_val("t1_first_valid", rnd_valid, 1);
    check_val("t1_first_byte", rnd_out, 8'h14);
    check_val("t1_level", fifo_level, 1);

    // Backpressure: FIFO fills to 4 and the divider stops.
    for (int k = 12; k <= 22; k++) begin
      cyc();
      check_val("t2_strobe", sample_en, (k <= 16 && k % 2 == 0) ? 1 : 0);
      if (k >= 17) check_val("t2_level_full", fifo_level, 4);
    end
    cyc();
    rnd_ready = 1'b1;
    check_val("t2_head", rnd_out, 8'h14);
    cyc();
    rnd_ready = 1'b0;
    check_val("t2_level_after_pop", fifo_level, 3);
    check_val("t2_new_head", rnd_out, 8'h15);
    check_val("t2_no_strobe_yet", sample_en, 0);
    cyc();
    check_val("t2_strobe_resume", sample_en, 1);
    cyc();
    check_val("t2_refill", fifo_level, 4);

    // en drop in RUN with 3 bytes left after one pop; they drain in order.
    check_val("t5_held_strobe", sample_en, 0);
    en = 1'b0;
    rnd_ready = 1'b1;
    cyc();
    rnd_ready = 1'b0;
    check_val("t5_state_idle", state, 0);
    check_val("t5_level", fifo_level, 3);
    check_val("t5_head", rnd_out, 8'h16);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check_val("t5_idle_strobe", sample_en, 0);
      check_val("t5_idle_level", fifo_level, 3);
    end
    cyc();
    rnd_ready = 1'b1;
    cyc(); cyc(); cyc();
    rnd_ready = 1'b0;
    check_val("t5_drained_level", fifo_level, 0);
    check_val("t5_drained_valid", rnd_valid, 0);

    // Constant A5 in RUN: two pushes, third equal sample faults and flushes.
    en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check_val("t3_strobe", sample_en, (k % 2 == 0) ? 1 : 0);
      check_val("t3_state", state, (k <= 8) ? 1 : 2);
    end
    cyc();
    check_val("t3_level", fifo_level, 2);
    check_val("t3_head", rnd_out, 8'hA5);
    cyc();
    check_val("t3_fail_strobe", sample_en, 1);
    check_val("t3_still_run", state, 2);
    cyc();
    check_val("t3_fault_state", state, 3);
    check_val("t3_fault_flag", fault, 1);
    check_val("t3_fault_strobe", sample_en, 0);
    cyc();
    check_val("t3_flushed_level", fifo_level, 0);
    check_val("t3_flushed_valid", rnd_valid, 0);
    check_val("t3_fault_held", fault, 1);
    cyc();
    check_val("t3_en_ignored", state, 3);
    cyc();
    clr_fault = 1'b1;
    cyc();
    clr_fault = 1'b0;
    rnd_ready = 1'b1;
    check_val("t3_clr_idle", state, 0);
    check_val("t3_clr_fault", fault, 0);
    cyc();
    check_val("t3_rewarm", state, 1);

    // Pattern A5,A5,3C,3C,3C after a fresh 4-sample warm-up: fault on the 5th.
    for (int k = 21; k <= 27; k++) begin
      cyc();
      check_val("t4_warm_strobe", sample_en, (k % 2 == 1) ? 1 : 0);
      check_val("t4_warm_state", state, 1);
    end
    cyc();
    check_val("t4_run", state, 2);
    for (int k = 29; k <= 37; k++) begin
      cyc();
      check_val("t4_run_state", state, 2);
      check_val("t4_run_strobe", sample_en, (k % 2 == 1) ? 1 : 0);
    end
    cyc();
    check_val("t4_fault_state", state, 3);
    check_val("t4_fault_flag", fault, 1);
    check_val("pop_count", popped.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < popped.size()) check_val("pop_data", popped[i], exp_pop[i]);
    end

    // Asynchronous reset with the FIFO half full.
    cyc();
    clr_fault = 1'b1;
    rnd_ready = 1'b0;
    cyc();
    clr_fault = 1'b0;
    waited = 0;
    while (fifo_level != 3'd2 && waited < 40) begin
      cyc();
      waited++;
    end
    check_val("t6_fill_in_time", (waited < 40) ? 1 : 0, 1);
    check_val("t6_state_run", state, 2);
    check_val("t6_head", rnd_out, 8'h44);
    #1 rstn = 1'b0;
    #1;
    check_val("t6_rst_state", state, 0);
    check_val("t6_rst_strobe", sample_en, 0);
    check_val("t6_rst_valid", rnd_valid, 0);
    check_val("t6_rst_out", rnd_out, 0);
    check_val("t6_rst_level", fifo_level, 0);
    check_val("t6_rst_fault", fault, 0);
    en = 1'b0;
    cyc();
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check_val("t6_post_strobe", sample_en, 0);
      check_val("t6_post_state", state, 0);
    end
    en = 1'b1;
    cyc();
    check_val("t6_restart_state", state, 1);
    check_val("t6_restart_nostrobe", sample_en, 0);
    cyc();
    check_val("t6_restart_strobe", sample_en, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/strng_ctrl.md
Name: strng_ctrl

Overview:
- Sequencing controller for strng_core.
- Generates the core's sample strobe from the single system clock instead of a gated clock.
- Discards a warm-up run of samples, then runs a repetition-count health test on each sampled byte.
- Buffers passing bytes in a small FIFO and serves them over a valid/ready stream; latches a fault on health-test failure.

Parameters:
- DIV_VAL, 24: sample strobe period is DIV_VAL+1 clk cycles (24 gives 2 MHz at 50 MHz).
- WARMUP, 256: number of samples discarded after each start.
- REP_LIMIT, 8: consecutive identical bytes that trigger FAULT (legal range 2..255).
- FIFO_DEPTH, 8: output buffer depth; power of 2, at least 2.
- DW, 8: random data width.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- en  in  1  run request; level-sensitive.
- clr_fault  in  1  single-cycle pulse that clears FAULT.
- rnd_data  in  DW  raw byte from strng_core.
- sample_en  out  1  one-cycle strobe; strng_core samples on it and rnd_data is captured in the same cycle.
- rnd_valid  out  1  FIFO not empty.
- rnd_ready  in  1  consumer accepts rnd_out.
- rnd_out  out  DW  FIFO head (first-word fall-through).
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- state  out  2  IDLE=0, WARMUP=1, RUN=2, FAULT=3.
- fault  out  1  high while in FAULT.

Behaviour:
- Reset (async, rstn=0): state=IDLE, sample_en=0, rnd_valid=0, rnd_out=0, fifo_level=0, fault=0; all counters and the last-byte register are cleared.
- Divider:
  - counts 0..DIV_VAL, only in WARMUP or RUN;
  - cleared on entry to WARMUP;
  - sample_en=1 exactly when counter==DIV_VAL, so the first strobe comes DIV_VAL+1 cycles after WARMUP entry;
  - in RUN, the counter holds (no strobe) while the FIFO is full. This is backpressure: no sample is ever dropped.
- Sample capture: on a sample_en cycle, rnd_data is registered as the current sample s.
- Health test (WARMUP and RUN):
  - first sample after WARMUP entry: last=s, rep=1;
  - later samples: if s==last then rep=rep+1, else rep=1 and last=s;
  - when rep reaches REP_LIMIT, next state=FAULT and s is not pushed.
- FSM:
  - IDLE: sample_en held 0. en=1 -> WARMUP.
  - WARMUP: counts samples. After the WARMUP-th sample -> RUN. Warm-up samples are never pushed. en=0 -> IDLE.
  - RUN: each passing sample is pushed to the FIFO. en=0 -> IDLE; the FIFO is kept and stays drainable.
  - FAULT: fault=1, sample_en=0, FIFO flushed on entry (level goes to 0 the cycle after entry). clr_fault -> IDLE. en is ignored while in FAULT.
- Priority within a cycle: health-test failure > en=0 > normal transition. A failing sample on the same cycle as en falling goes to FAULT.
- Re-entry to WARMUP always restarts the warm-up count, the health-test history and the divider.
- FIFO:
  - push and pop in the same cycle leave the level unchanged;
  - pop happens on rnd_valid && rnd_ready;
  - a pop while empty is impossible (rnd_valid=0);
  - a push while full is impossible because the divider holds;
  - pointers wrap modulo FIFO_DEPTH, with an extra bit used for full/empty.
- Latency: a passing sample captured at cycle N is visible on rnd_out/rnd_valid at N+1 if the FIFO was empty.
- Reset mid-operation: immediate return to reset values, and the FIFO contents are lost.

Decomposition:
- Package strng_pkg holds:
  - state encoding constants ST_IDLE, ST_WARMUP, ST_RUN, ST_FAULT;
  - the default DIV_VAL values for 50, 25, 10, 5, 2 and 1 MHz sample rates (0, 1, 4, 9, 24, 49).
- One sub-module: strng_fifo (sync FWFT FIFO with parameters DW and FIFO_DEPTH; ports push, pop, flush, full, empty, level).
- The FSM, divider and health test stay in strng_ctrl.

Test Plan (DIV_VAL=1, WARMUP=4, REP_LIMIT=3, FIFO_DEPTH=4 unless stated):
- Reset, then en=1, rnd_data incrementing every strobe -> strobes every 2 cycles; state=WARMUP for 4 strobes, then RUN; first pushed byte equals the 5th sampled value; rnd_valid rises 1 cycle after that capture.
- RUN with rnd_ready=0 -> fifo_level reaches 4, then sample_en stays 0. Raise rnd_ready for one cycle -> level 3, and strobes resume after DIV_VAL+1 cycles.
- In RUN, rnd_data held at 8'hA5 -> 2 bytes of 8'hA5 pushed; the 3rd equal sample sets FAULT, fault=1, fifo_level=0; clr_fault -> IDLE; en still 1 -> WARMUP restarts its count from 0.
- Repeat pattern A5,A5,3C,3C,3C in RUN -> FAULT on the 5th sample, not the 2nd; A5,A5,3C,3C are pushed.
- en dropped in RUN with 3 bytes buffered -> IDLE, no further strobes, the 3 bytes are drained in order with rnd_ready=1.
- rstn asserted mid-RUN with the FIFO half full -> all outputs return to reset values asynchronously, with no strobe after release until en is seen high.
